dp_operand_loader: RTL and testbench
====================================

# dp_operand_loader

Front-end feeder for the dot-product engine. Accepts pixel/weight pairs one element per cycle over a valid/ready stream, packs them into the flat `Pixels`/`Weights` buses, and issues a clear pulse to the engine to start a pass. It then waits the engine's fixed compute latency, captures `value`, and presents it on a valid/ready result port. It sits between the window/weight fetch logic and one dot-product instance.

## Interface
Parameters:
- `PIXEL_N`, 10, elements per dot product
- `PIXEL_SIZE`, 10, pixel width
- `WEIGHT_SIZE`, 19, weight width
- `VAL_SIZE`, 26, result width
- `FPM_DELAY`, 6, engine multiplier wait count
- `FPA_DELAY`, 2, engine adder wait count
- `PARALLEL`, 1, engine lanes; must divide `PIXEL_N`
- `CLR_CYCLES`, 3, length of the engine clear pulse; minimum 2

Ports:
- `clk`  in  1  clock
- `GlobalReset`  in  1  reset: asynchronous, active-high
- `in_valid`  in  1  element valid
- `in_ready`  out  1  loader accepts an element
- `in_pixel`  in  `PIXEL_SIZE`  pixel element
- `in_weight`  in  `WEIGHT_SIZE`  weight element
- `dp_clear`  out  1  drives the engine's reset input
- `dp_pixels`  out  `PIXEL_N*PIXEL_SIZE`  to engine `Pixels`
- `dp_weights`  out  `PIXEL_N*WEIGHT_SIZE`  to engine `Weights`
- `dp_value`  in  `VAL_SIZE`  from engine `value`
- `res_valid`  out  1  result valid
- `res_ready`  in  1  result consumer ready
- `res_value`  out  `VAL_SIZE`  captured dot product
- `busy`  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, LOAD, CLEAR, RUN, HOLD.
- IDLE: `in_ready`=1. The first accepted element moves the FSM to LOAD with `ld_idx`=1.
- LOAD: element k is written to slice `[k*PIXEL_SIZE +: PIXEL_SIZE]` (weights likewise), element 0 at the LSB. Acceptance is `in_valid & in_ready`. After element `PIXEL_N-1` is accepted, the FSM goes to CLEAR.
- CLEAR: `dp_clear`=1 for exactly `CLR_CYCLES` cycles. The operand buses are frozen. The FSM then goes to RUN with `run_cnt`=0.
- RUN: `run_cnt` counts to `RUN_LAT-1`, where `RUN_LAT = (PIXEL_N/PARALLEL)*(FPM_DELAY+FPA_DELAY+4) + 1`; this is 121 for the defaults. At `run_cnt == RUN_LAT-1`, `dp_value` is registered into `res_value` and the FSM goes to HOLD.
- HOLD: `res_valid`=1, and `res_value` is stable until `res_ready`. On handshake the FSM returns to IDLE.
- `dp_pixels`/`dp_weights` change only in LOAD, or in the double-buffer case described under Configuration. They are unchanged through CLEAR and RUN.
- No arithmetic is performed; widths are passed through unmodified.
- Reset mid-operation: state goes to IDLE, all counters clear, and any partial load is discarded.

## Timing
- Reset values: `in_ready`=0 during reset and 1 on the first cycle after release (IDLE); `dp_clear`=1 during reset, so the engine is held cleared; `dp_pixels`=0, `dp_weights`=0, `res_valid`=0, `res_value`=0, `busy`=0.
- In IDLE after reset, `dp_clear` is 0. The engine may free-run on zero operands; its output is ignored.
- Load takes `PIXEL_N` accepted beats; back-to-back `in_valid` gives `PIXEL_N` cycles.
- Minimum latency from the last element accepted to `res_valid`: `CLR_CYCLES + RUN_LAT` + 1 cycles, which is 125 for the defaults.
- `in_valid` low during LOAD stalls `ld_idx`. There is no timeout.
- `res_ready` held high in HOLD completes the handshake in the first HOLD cycle.
- All outputs are registered.

## Configuration
- `DP_LOADER_DBLBUF_EN` defined:
  - A second (shadow) operand bank is added. `in_ready` stays 1 during CLEAR, RUN and HOLD until the shadow bank is full.
  - On leaving HOLD with a full shadow bank, the shadow is copied to the live buses and the FSM goes directly to CLEAR, skipping LOAD.
  - A partial shadow fill carries over into LOAD with its index preserved.
- `DP_LOADER_DBLBUF_EN` undefined: there is a single bank, and `in_ready`=0 in CLEAR, RUN and HOLD.

## Structure
- Shared package `dp_pkg` holds:
  - the state encoding localparams;
  - the `RUN_LAT` computation as a constant function of `PIXEL_N`, `PARALLEL`, `FPM_DELAY` and `FPA_DELAY`, reused by the engine bench.
- One sub-module, `dp_operand_bank`: an indexed write into packed pixel/weight registers with a full flag. It is instantiated once, or twice when double buffering is enabled.

## Test plan
- Single vector:
  - Stimulus: pixels 1..10 and weights 10..1 back-to-back, `res_ready`=1.
  - Response: `dp_pixels[9:0]`=1 and `dp_pixels[99:90]`=10; `dp_clear` high 3 cycles; `res_valid` 125 cycles after the last beat; `res_value` equals `dp_value` at capture.
- Stalled load:
  - Stimulus: `in_valid` toggled every other cycle.
  - Response: load takes 19 cycles; bus packing is identical to the single-vector case.
- Result backpressure:
  - Stimulus: `res_ready`=0 for 50 cycles in HOLD.
  - Response: `res_valid` and `res_value` stay stable and `in_ready`=0 (non-DBLBUF); handshake in cycle 51 returns the FSM to IDLE.
- Reset mid-RUN:
  - Stimulus: `GlobalReset` pulsed at `run_cnt`=40.
  - Response: all outputs return to reset values; a new vector then completes normally.
- Double buffer (`DP_LOADER_DBLBUF_EN`):
  - Stimulus: vector B streamed during RUN of vector A.
  - Response: `dp_clear` for B asserts on the cycle after A's handshake; no LOAD state is observed.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared definitions for the dot-product operand loader and the engine bench:
// state encoding, engine run latency and a counter-width helper.
package dp_pkg;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_LOAD_ENC  = 3'd1;
  localparam logic [2:0] ST_CLEAR_ENC = 3'd2;
  localparam logic [2:0] ST_RUN_ENC   = 3'd3;
  localparam logic [2:0] ST_HOLD_ENC  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_LOAD  = ST_LOAD_ENC,
    ST_CLEAR = ST_CLEAR_ENC,
    ST_RUN   = ST_RUN_ENC,
    ST_HOLD  = ST_HOLD_ENC
  } dp_state_e;

  // Cycles from the end of the engine clear pulse until its value is final.
  function automatic int run_lat(input int pixel_n, input int parallel,
                                 input int fpm_delay, input int fpa_delay);
    return (pixel_n / parallel) * (fpm_delay + fpa_delay + 4) + 1;
  endfunction

  // Bits needed to hold any value in 0..max_val (at least one).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/dp_operand_bank.sv
// One operand bank: packed pixel/weight registers filled one element at a
// time, element 0 at the LSB. An optional copy-in loads the whole bank from
// another bank; a write in the same cycle lands after the copied elements.
// The next-cycle index and full flag are exposed so the controller can
// decide on the same cycle a write completes the bank.
module dp_operand_bank
  import dp_pkg::*;
#(
  parameter int PIXEL_N     = 10,
  parameter int PIXEL_SIZE  = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int IDX_W       = 4
) (
  input  logic                           clk,
  input  logic                           GlobalReset,
  input  logic                           wr_en,
  input  logic [PIXEL_SIZE-1:0]          wr_pixel,
  input  logic [WEIGHT_SIZE-1:0]         wr_weight,
  input  logic                           clr_idx,
  input  logic                           cp_en,
  input  logic [PIXEL_N*PIXEL_SIZE-1:0]  cp_pixels,
  input  logic [PIXEL_N*WEIGHT_SIZE-1:0] cp_weights,
  input  logic [IDX_W-1:0]               cp_idx,
  output logic [PIXEL_N*PIXEL_SIZE-1:0]  pixels,
  output logic [PIXEL_N*WEIGHT_SIZE-1:0] weights,
  output logic [IDX_W-1:0]               idx,
  output logic [IDX_W-1:0]               nxt_idx,
  output logic                           nxt_full
);

  logic [PIXEL_N*PIXEL_SIZE-1:0]  base_pix, nxt_pix;
  logic [PIXEL_N*WEIGHT_SIZE-1:0] base_wgt, nxt_wgt;
  logic [IDX_W-1:0]               base_idx;

  // Merge copy-in and indexed write into the next bank contents
  always_comb begin
    base_pix = cp_en ? cp_pixels  : pixels;
    base_wgt = cp_en ? cp_weights : weights;
    base_idx = cp_en ? cp_idx     : idx;
    nxt_pix  = base_pix;
    nxt_wgt  = base_wgt;
    nxt_idx  = base_idx;
    if (wr_en && (base_idx != IDX_W'(PIXEL_N))) begin
      for (int k = 0; k < PIXEL_N; k++) begin
        if (base_idx == IDX_W'(k)) begin
          nxt_pix[k*PIXEL_SIZE +: PIXEL_SIZE]   = wr_pixel;
          nxt_wgt[k*WEIGHT_SIZE +: WEIGHT_SIZE] = wr_weight;
        end
      end
      nxt_idx = base_idx + IDX_W'(1);
    end
  end

  assign nxt_full = (nxt_idx == IDX_W'(PIXEL_N));

  // Bank registers; clearing the index keeps the data frozen for the engine
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      pixels  <= '0;
      weights <= '0;
      idx     <= '0;
    end else begin
      pixels  <= nxt_pix;
      weights <= nxt_wgt;
      idx     <= clr_idx ? '0 : nxt_idx;
    end
  end

endmodule

// File: rtl/dp_operand_loader.sv
// Front-end feeder for one dot-product engine: packs a stream of
// pixel/weight elements onto the engine buses, pulses the engine clear,
// waits the engine latency, then holds the captured value on a valid/ready
// result port.
// Build option DP_LOADER_DBLBUF_EN adds a shadow bank so the next vector can
// stream in while the current one is computed and waiting in HOLD.
//
// state | meaning
// IDLE  | waiting for the first element of a vector
// LOAD  | accepting elements 1..PIXEL_N-1 into the live bank
// CLEAR | engine clear pulse, CLR_CYCLES long, buses frozen
// RUN   | waiting the engine latency, value captured on the last cycle
// HOLD  | result presented until the consumer takes it
module dp_operand_loader
  import dp_pkg::*;
#(
  parameter int PIXEL_N     = 10,
  parameter int PIXEL_SIZE  = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int VAL_SIZE    = 26,
  parameter int FPM_DELAY   = 6,
  parameter int FPA_DELAY   = 2,
  parameter int PARALLEL    = 1,   // must divide PIXEL_N
  parameter int CLR_CYCLES  = 3    // at least 2
) (
  input  logic                           clk,
  input  logic                           GlobalReset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PIXEL_SIZE-1:0]          in_pixel,
  input  logic [WEIGHT_SIZE-1:0]         in_weight,
  output logic                           dp_clear,
  output logic [PIXEL_N*PIXEL_SIZE-1:0]  dp_pixels,
  output logic [PIXEL_N*WEIGHT_SIZE-1:0] dp_weights,
  input  logic [VAL_SIZE-1:0]            dp_value,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [VAL_SIZE-1:0]            res_value,
  output logic                           busy
);

  localparam int RUN_LAT = run_lat(PIXEL_N, PARALLEL, FPM_DELAY, FPA_DELAY);
  localparam int RC_W    = cnt_width(RUN_LAT - 1);
  localparam int CC_W    = cnt_width(CLR_CYCLES - 1);
  localparam int IDX_W   = cnt_width(PIXEL_N);

  dp_state_e        state, state_nxt;
  logic [RC_W-1:0]  run_cnt;
  logic [CC_W-1:0]  clr_cnt;
  logic             accept, load_phase, hold_hs, run_done;
  logic             in_ready_nxt;

  logic             lv_wr, lv_cp, lv_clr, lv_nxt_full;
  logic [IDX_W-1:0] ld_idx, lv_nxt_idx;
  logic [PIXEL_N*PIXEL_SIZE-1:0]  lv_cp_pixels;
  logic [PIXEL_N*WEIGHT_SIZE-1:0] lv_cp_weights;
  logic [IDX_W-1:0]               lv_cp_idx;
  logic             unused_sink;

`ifdef DP_LOADER_DBLBUF_EN
  logic             sh_wr, sh_clr, sh_nxt_full;
  logic [IDX_W-1:0] sh_idx, sh_nxt_idx;
  logic [PIXEL_N*PIXEL_SIZE-1:0]  sh_pixels;
  logic [PIXEL_N*WEIGHT_SIZE-1:0] sh_weights;
`endif

  assign accept     = in_valid && in_ready;
  assign load_phase = (state == ST_IDLE) || (state == ST_LOAD);
  assign hold_hs    = (state == ST_HOLD) && res_ready;
  assign run_done   = (run_cnt == RC_W'(RUN_LAT - 1));
  // Only the index restarts on entering CLEAR; the data stays on the buses.
  assign lv_clr     = (state_nxt == ST_CLEAR);

  // Next-state decode, write steering between banks and next in_ready
  always_comb begin
    state_nxt    = state;
    lv_wr        = 1'b0;
    lv_cp        = 1'b0;
    in_ready_nxt = 1'b0;
`ifdef DP_LOADER_DBLBUF_EN
    sh_wr  = 1'b0;
    sh_clr = 1'b0;
    // On the result handshake the shadow moves to the live bank, and an
    // element arriving in that same cycle follows it there.
    lv_wr  = accept && (load_phase || hold_hs);
    lv_cp  = hold_hs && (sh_idx != '0);
    sh_wr  = accept && !load_phase && !hold_hs;
    sh_clr = hold_hs;
`else
    lv_wr  = accept && load_phase;
`endif
    case (state)
      ST_IDLE:  if (accept) state_nxt = lv_nxt_full ? ST_CLEAR : ST_LOAD;
      ST_LOAD:  if (lv_nxt_full) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_cnt == '0) state_nxt = ST_RUN;
      ST_RUN:   if (run_done) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (res_ready) begin
`ifdef DP_LOADER_DBLBUF_EN
          if (lv_nxt_full)             state_nxt = ST_CLEAR;
          else if (lv_nxt_idx != '0)   state_nxt = ST_LOAD;
          else                         state_nxt = ST_IDLE;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
    in_ready_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD);
`ifdef DP_LOADER_DBLBUF_EN
    in_ready_nxt = in_ready_nxt || hold_hs || !sh_nxt_full;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Clear-pulse down-counter and engine latency counter
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      clr_cnt <= '0;
      run_cnt <= '0;
    end else begin
      if ((state_nxt == ST_CLEAR) && (state != ST_CLEAR))
        clr_cnt <= CC_W'(CLR_CYCLES - 1);
      else if ((state == ST_CLEAR) && (clr_cnt != '0))
        clr_cnt <= clr_cnt - CC_W'(1);
      if ((state == ST_RUN) && (state_nxt == ST_RUN))
        run_cnt <= run_cnt + RC_W'(1);
      else
        run_cnt <= '0;
    end
  end

  // Registered control outputs and result capture
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      in_ready  <= 1'b0;
      dp_clear  <= 1'b1;
      res_valid <= 1'b0;
      res_value <= '0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= in_ready_nxt;
      dp_clear  <= (state_nxt == ST_CLEAR);
      res_valid <= (state_nxt == ST_HOLD);
      busy      <= (state_nxt != ST_IDLE);
      if ((state == ST_RUN) && run_done) res_value <= dp_value;
    end
  end

`ifdef DP_LOADER_DBLBUF_EN
  assign lv_cp_pixels  = sh_pixels;
  assign lv_cp_weights = sh_weights;
  assign lv_cp_idx     = sh_idx;
  assign unused_sink   = ^{ld_idx, sh_nxt_idx};

  dp_operand_bank #(
    .PIXEL_N     (PIXEL_N),
    .PIXEL_SIZE  (PIXEL_SIZE),
    .WEIGHT_SIZE (WEIGHT_SIZE),
    .IDX_W       (IDX_W)
  ) u_shadow_bank (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .wr_en       (sh_wr),
    .wr_pixel    (in_pixel),
    .wr_weight   (in_weight),
    .clr_idx     (sh_clr),
    .cp_en       (1'b0),
    .cp_pixels   ('0),
    .cp_weights  ('0),
    .cp_idx      ('0),
    .pixels      (sh_pixels),
    .weights     (sh_weights),
    .idx         (sh_idx),
    .nxt_idx     (sh_nxt_idx),
    .nxt_full    (sh_nxt_full)
  );
`else
  assign lv_cp_pixels  = '0;
  assign lv_cp_weights = '0;
  assign lv_cp_idx     = '0;
  assign unused_sink   = ^{ld_idx, lv_nxt_idx};
`endif

  dp_operand_bank #(
    .PIXEL_N     (PIXEL_N),
    .PIXEL_SIZE  (PIXEL_SIZE),
    .WEIGHT_SIZE (WEIGHT_SIZE),
    .IDX_W       (IDX_W)
  ) u_live_bank (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .wr_en       (lv_wr),
    .wr_pixel    (in_pixel),
    .wr_weight   (in_weight),
    .clr_idx     (lv_clr),
    .cp_en       (lv_cp),
    .cp_pixels   (lv_cp_pixels),
    .cp_weights  (lv_cp_weights),
    .cp_idx      (lv_cp_idx),
    .pixels      (dp_pixels),
    .weights     (dp_weights),
    .idx         (ld_idx),
    .nxt_idx     (lv_nxt_idx),
    .nxt_full    (lv_nxt_full)
  );

endmodule

// File: tb/tb_dp_operand_loader.sv
// Self-checking bench for dp_operand_loader. A cycle-indexed stand-in for the
// engine drives dp_value, so the expected captured value and the cycle of
// res_valid are both known when a vector is loaded; they are queued then and
// checked when the result appears. Define DP_LOADER_DBLBUF_EN for both
// bench and RTL to exercise the shadow bank.
`timescale 1ns/1ps
module tb_dp_operand_loader;

  localparam int PIXEL_N     = 10;
  localparam int PIXEL_SIZE  = 10;
  localparam int WEIGHT_SIZE = 19;
  localparam int VAL_SIZE    = 26;
  localparam int FPM_DELAY   = 6;
  localparam int FPA_DELAY   = 2;
  localparam int PARALLEL    = 1;
  localparam int CLR_CYCLES  = 3;
  localparam int RUN_LAT     = (PIXEL_N / PARALLEL) * (FPM_DELAY + FPA_DELAY + 4) + 1;
  localparam int LAT         = CLR_CYCLES + RUN_LAT + 1;   // 125
  localparam int PW          = PIXEL_N * PIXEL_SIZE;
  localparam int WW          = PIXEL_N * WEIGHT_SIZE;

  logic                   clk;
  logic                   GlobalReset;
  logic                   in_valid, in_ready;
  logic [PIXEL_SIZE-1:0]  in_pixel;
  logic [WEIGHT_SIZE-1:0] in_weight;
  logic                   dp_clear;
  logic [PW-1:0]          dp_pixels;
  logic [WW-1:0]          dp_weights;
  logic [VAL_SIZE-1:0]    dp_value;
  logic                   res_valid, res_ready;
  logic [VAL_SIZE-1:0]    res_value;
  logic                   busy;

  dp_operand_loader #(
    .PIXEL_N(PIXEL_N), .PIXEL_SIZE(PIXEL_SIZE), .WEIGHT_SIZE(WEIGHT_SIZE),
    .VAL_SIZE(VAL_SIZE), .FPM_DELAY(FPM_DELAY), .FPA_DELAY(FPA_DELAY),
    .PARALLEL(PARALLEL), .CLR_CYCLES(CLR_CYCLES)
  ) dut (
    .clk(clk), .GlobalReset(GlobalReset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_weight(in_weight),
    .dp_clear(dp_clear), .dp_pixels(dp_pixels), .dp_weights(dp_weights),
    .dp_value(dp_value),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VAL_SIZE-1:0] dv_of(input int c);
    logic [31:0] t;
    t = c * 32'h0001_9E37 + 32'h0000_1234;
    return t[VAL_SIZE-1:0];
  endfunction

  assign dp_value = dv_of(cyc);

  typedef struct {
    logic [PW-1:0]       pix;
    logic [WW-1:0]       wgt;
    logic [VAL_SIZE-1:0] val;
    int                  vcyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [PIXEL_SIZE-1:0]  pv [PIXEL_N];
  logic [WEIGHT_SIZE-1:0] wv [PIXEL_N];
  int first_cyc, last_cyc;

  function automatic logic [PW-1:0] pack_pix();
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < PIXEL_N; k++) r[k*PIXEL_SIZE +: PIXEL_SIZE] = pv[k];
    return r;
  endfunction

  function automatic logic [WW-1:0] pack_wgt();
    logic [WW-1:0] r;
    r = '0;
    for (int k = 0; k < PIXEL_N; k++) r[k*WEIGHT_SIZE +: WEIGHT_SIZE] = wv[k];
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp();
    for (int k = 0; k < PIXEL_N; k++) begin
      pv[k] = PIXEL_SIZE'(k + 1);
      wv[k] = WEIGHT_SIZE'(PIXEL_N - k);
    end
  endtask

  task automatic set_random();
    for (int k = 0; k < PIXEL_N; k++) begin
      pv[k] = PIXEL_SIZE'($urandom);
      wv[k] = WEIGHT_SIZE'($urandom);
    end
  endtask

  // Streams pv/wv; returns in the cycle after the last accepted beat.
  task automatic load_vec(input bit stall, input bit push);
    int   k, guard;
    bit   v;
    exp_t e;
    k = 0;
    guard = 0;
    while (k < PIXEL_N && guard < 200) begin
      v = stall ? ((guard % 2) == 0) : 1'b1;
      in_valid  = v;
      in_pixel  = pv[k];
      in_weight = wv[k];
      if (v && in_ready) begin
        if (k == 0) first_cyc = cyc;
        if (k == PIXEL_N - 1) last_cyc = cyc;
        k++;
      end
      next_cycle();
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    if (k != PIXEL_N) begin
      errors++;
      $display("FAIL load_timeout: accepted %0d beats, required %0d", k, PIXEL_N);
    end
    if (push) begin
      e.pix  = pack_pix();
      e.wgt  = pack_wgt();
      e.vcyc = last_cyc + LAT;
      e.val  = dv_of(last_cyc + LAT - 1);
      sb.push_back(e);
    end
  endtask

  // Called in the first cycle after the last beat: CLEAR window and buses.
  task automatic check_clear_phase();
    for (int i = 0; i < CLR_CYCLES; i++) begin
      checks++;
      if (dp_clear !== 1'b1) begin
        errors++;
        $display("FAIL clear_pulse[%0d]: dp_clear=%b required 1", i, dp_clear);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_clear[%0d]: busy=%b required 1", i, busy);
      end
`ifndef DP_LOADER_DBLBUF_EN
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL in_ready_clear[%0d]: in_ready=%b required 0", i, in_ready);
      end
`endif
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: no expected vector queued");
      end else if (dp_pixels !== sb[0].pix || dp_weights !== sb[0].wgt) begin
        errors++;
        $display("FAIL bus_pack: pixels=%h weights=%h required %h %h",
                 dp_pixels, dp_weights, sb[0].pix, sb[0].wgt);
      end
      next_cycle();
    end
    checks++;
    if (dp_clear !== 1'b0) begin
      errors++;
      $display("FAIL clear_end: dp_clear=%b required 0 after %0d cycles", dp_clear, CLR_CYCLES);
    end
  endtask

  // Waits for res_valid, then pops the scoreboard and checks cycle and value.
  task automatic wait_result();
    int   n;
    exp_t e;
    n = 0;
    while (res_valid !== 1'b1 && n < 400) begin
      next_cycle();
      n++;
    end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL res_timeout: res_valid=%b required 1 within 400 cycles", res_valid);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: result with no expected vector");
    end else begin
      e = sb.pop_front();
      checks++;
      if (cyc != e.vcyc) begin
        errors++;
        $display("FAIL res_latency: res_valid at cycle %0d required %0d", cyc, e.vcyc);
      end
      checks++;
      if (res_value !== e.val) begin
        errors++;
        $display("FAIL res_value: res_value=%h required %h", res_value, e.val);
      end
    end
  endtask

  task automatic check_idle_after_hs();
    next_cycle();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_hs: res_valid=%b busy=%b in_ready=%b required 0 0 1",
               res_valid, busy, in_ready);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (in_ready !== 1'b0 || dp_clear !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl: in_ready=%b dp_clear=%b res_valid=%b busy=%b required 0 1 0 0",
               tag, in_ready, dp_clear, res_valid, busy);
    end
    checks++;
    if (dp_pixels !== '0 || dp_weights !== '0 || res_value !== '0) begin
      errors++;
      $display("FAIL %s_data: pixels=%h weights=%h res_value=%h required all 0",
               tag, dp_pixels, dp_weights, res_value);
    end
  endtask

  task automatic check_released(input string tag);
    checks++;
    if (in_ready !== 1'b1 || dp_clear !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: in_ready=%b dp_clear=%b busy=%b required 1 0 0",
               tag, in_ready, dp_clear, busy);
    end
  endtask

  task automatic test_reset();
    GlobalReset = 1'b1;
    repeat (3) next_cycle();
    check_reset_values("reset");
    GlobalReset = 1'b0;
    next_cycle();
    check_released("reset");
  endtask

  task automatic run_vector(input bit stall);
    res_ready = 1'b1;
    load_vec(stall, 1'b1);
    check_clear_phase();
    wait_result();
    check_idle_after_hs();
  endtask

  task automatic test_single();
    set_ramp();
    res_ready = 1'b1;
    load_vec(1'b0, 1'b1);
    checks++;
    if (dp_pixels[PIXEL_SIZE-1:0] !== PIXEL_SIZE'(1) ||
        dp_pixels[PW-1 -: PIXEL_SIZE] !== PIXEL_SIZE'(PIXEL_N)) begin
      errors++;
      $display("FAIL pixel_ends: low=%0d high=%0d required 1 %0d",
               dp_pixels[PIXEL_SIZE-1:0], dp_pixels[PW-1 -: PIXEL_SIZE], PIXEL_N);
    end
    checks++;
    if (last_cyc - first_cyc + 1 != PIXEL_N) begin
      errors++;
      $display("FAIL load_len: %0d cycles required %0d", last_cyc - first_cyc + 1, PIXEL_N);
    end
    check_clear_phase();
    wait_result();
    check_idle_after_hs();
  endtask

  task automatic test_stall();
    set_ramp();
    run_vector(1'b1);
    checks++;
    if (last_cyc - first_cyc + 1 != 2 * PIXEL_N - 1) begin
      errors++;
      $display("FAIL stall_len: %0d cycles required %0d",
               last_cyc - first_cyc + 1, 2 * PIXEL_N - 1);
    end
  endtask

  task automatic test_backpressure();
    logic [VAL_SIZE-1:0] held;
    set_random();
    res_ready = 1'b0;
    load_vec(1'b0, 1'b1);
    check_clear_phase();
    wait_result();
    held = res_value;
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_value !== held) begin
        errors++;
        $display("FAIL hold_stable[%0d]: res_valid=%b res_value=%h required 1 %h",
                 i, res_valid, res_value, held);
      end
`ifndef DP_LOADER_DBLBUF_EN
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_in_ready[%0d]: in_ready=%b required 0", i, in_ready);
      end
`endif
      next_cycle();
    end
    res_ready = 1'b1;
    check_idle_after_hs();
  endtask

  task automatic test_reset_mid_run();
    set_random();
    res_ready = 1'b1;
    load_vec(1'b0, 1'b1);
    repeat (CLR_CYCLES + 40) next_cycle();
    GlobalReset = 1'b1;
    #1;
    check_reset_values("midrun");
    sb.delete();
    next_cycle();
    GlobalReset = 1'b0;
    next_cycle();
    check_released("midrun");
    set_random();
    run_vector(1'b0);
  endtask

`ifdef DP_LOADER_DBLBUF_EN
  task automatic test_dblbuf();
    exp_t e;
    set_random();
    res_ready = 1'b1;
    load_vec(1'b0, 1'b1);
    set_random();
    load_vec(1'b0, 1'b0);
    wait_result();
    e.pix  = pack_pix();
    e.wgt  = pack_wgt();
    e.vcyc = cyc + LAT;
    e.val  = dv_of(cyc + LAT - 1);
    sb.push_back(e);
    next_cycle();
    checks++;
    if (dp_clear !== 1'b1 || busy !== 1'b1 || dp_pixels !== e.pix || dp_weights !== e.wgt) begin
      errors++;
      $display("FAIL dblbuf_swap: dp_clear=%b busy=%b pixels=%h required 1 1 %h",
               dp_clear, busy, dp_pixels, e.pix);
    end
    wait_result();
    check_idle_after_hs();
  endtask
`endif

  initial begin
    GlobalReset = 1'b1;
    in_valid    = 1'b0;
    in_pixel    = '0;
    in_weight   = '0;
    res_ready   = 1'b0;
    #1;
    test_reset();
    test_single();
    test_stall();
    test_backpressure();
    test_reset_mid_run();
`ifdef DP_LOADER_DBLBUF_EN
    test_dblbuf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
